// File: rtl/fence_ctrl_pkg.sv
// Shared types for the fence/flush sequencer.
//   fence_type_e  : encoding of the fence class presented on req_type_i
//   fence_state_e : sequencer state register encoding
//   fence_is_legal: decides whether a raw request type may be executed
package fence_ctrl_pkg;

  typedef enum logic [2:0] {
    FENCE       = 3'd0,
    FENCE_I     = 3'd1,
    SFENCE_VMA  = 3'd2,
    HFENCE_VVMA = 3'd3,
    HFENCE_GVMA = 3'd4
  } fence_type_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DRAIN     = 3'd1,
    ST_FLUSH_DC  = 3'd2,
    ST_FLUSH_IC  = 3'd3,
    ST_FLUSH_TLB = 3'd4,
    ST_DONE      = 3'd5,
    ST_ILLEGAL   = 3'd6
  } fence_state_e;

  // Hypervisor fences only exist when the H extension is configured.
  function automatic logic fence_is_legal(input logic [2:0] req_type, input logic rvh);
    logic legal;
    legal = 1'b0;
    case (req_type)
      3'd0, 3'd1, 3'd2: legal = 1'b1;
      3'd3, 3'd4:       legal = rvh;
      default:          legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/fence_flush_ctrl_sat_counter.sv
// Clearable saturating up-counter.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : load zero (has priority over increment)
//   inc_i         : count up by one, sticking at all-ones
//   cnt_o         : current count
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != {Width{1'b1}})) begin
      cnt_o <= cnt_o + Width'(1);
    end
  end

endmodule

// File: rtl/fence_flush_ctrl.sv
// Fence sequencer at commit. Accepts one fence-class instruction at a time,
// waits for the store buffer and D$ write buffer to drain, then issues the
// D$ / I$ / TLB flush commands the fence needs in a fixed order and reports
// completion with a single done pulse.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   req_valid_i/type_i   : fence request from commit; req_ready_o high in IDLE
//   stb_empty_i          : store buffer empty
//   wbuf_empty_i         : D$ write buffer empty
//   flush_dcache_o       : level request to D$, held until flush_dcache_ack_i
//   flush_icache_o       : one-cycle I$ flush pulse
//   flush_tlb_*_o        : one-cycle TLB flush pulses (SFENCE / HFENCE.VVMA / HFENCE.GVMA)
//   done_o, illegal_o    : one-cycle completion / rejection pulses
//   busy_o               : sequencer not idle
//   busy_cycles_o        : non-idle cycles of the last or current request (saturating)
module fence_flush_ctrl
  import fence_ctrl_pkg::*;
#(
  parameter bit          DcacheFlushOnFence = 1'b0,
  parameter bit          DcacheWriteBack    = 1'b0,
  parameter bit          RVH                = 1'b1,
  parameter int unsigned CntWidth           = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  input  logic [2:0]          req_type_i,
  output logic                req_ready_o,
  input  logic                stb_empty_i,
  input  logic                wbuf_empty_i,
  output logic                flush_dcache_o,
  input  logic                flush_dcache_ack_i,
  output logic                flush_icache_o,
  output logic                flush_tlb_o,
  output logic                flush_tlb_vvma_o,
  output logic                flush_tlb_gvma_o,
  output logic                done_o,
  output logic                illegal_o,
  output logic                busy_o,
  output logic [CntWidth-1:0] busy_cycles_o
);

  fence_state_e state;
  fence_type_e  type_q;
  logic         accept;

  assign accept = req_valid_i && (state == ST_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= ST_IDLE;
      type_q <= FENCE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            type_q <= fence_type_e'(req_type_i);
            state  <= fence_is_legal(req_type_i, RVH) ? ST_DRAIN : ST_ILLEGAL;
          end
        end
        ST_DRAIN: begin
          if (stb_empty_i && wbuf_empty_i) begin
            case (type_q)
              FENCE:   state <= DcacheFlushOnFence ? ST_FLUSH_DC : ST_DONE;
              // A write-back D$ may hold dirty lines the I$ must observe.
              FENCE_I: state <= (DcacheFlushOnFence || DcacheWriteBack) ? ST_FLUSH_DC : ST_FLUSH_IC;
              default: state <= ST_FLUSH_TLB;
            endcase
          end
        end
        ST_FLUSH_DC: begin
          if (flush_dcache_ack_i) begin
            state <= (type_q == FENCE_I) ? ST_FLUSH_IC : ST_DONE;
          end
        end
        ST_FLUSH_IC:  state <= ST_DONE;
        ST_FLUSH_TLB: state <= ST_DONE;
        ST_DONE:      state <= ST_IDLE;
        ST_ILLEGAL:   state <= ST_IDLE;
        default:      state <= ST_IDLE;
      endcase
    end
  end

  // All outputs are decodes of registered state, so reset clears them
  // asynchronously and nothing on req_* reaches a flush output in the same cycle.
  assign req_ready_o      = (state == ST_IDLE);
  assign busy_o           = (state != ST_IDLE);
  assign flush_dcache_o   = (state == ST_FLUSH_DC);
  assign flush_icache_o   = (state == ST_FLUSH_IC);
  assign flush_tlb_o      = (state == ST_FLUSH_TLB) && (type_q == SFENCE_VMA);
  assign flush_tlb_vvma_o = (state == ST_FLUSH_TLB) && (type_q == HFENCE_VVMA);
  assign flush_tlb_gvma_o = (state == ST_FLUSH_TLB) && (type_q == HFENCE_GVMA);
  assign done_o           = (state == ST_DONE);
  assign illegal_o        = (state == ST_ILLEGAL);

  sat_counter #(
    .Width (CntWidth)
  ) u_busy_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (accept),
    .inc_i  (busy_o),
    .cnt_o  (busy_cycles_o)
  );

endmodule

// File: tb/tb_fence_flush_ctrl.sv
// Directed bench for fence_flush_ctrl. Four instances share one stimulus:
// write-through D$, write-back D$, no hypervisor, and a 4-bit busy counter.
module tb_fence_flush_ctrl;

  localparam int W = 0;  // defaults (WT D$, RVH=1)
  localparam int B = 1;  // DcacheWriteBack=1
  localparam int N = 2;  // RVH=0
  localparam int C = 3;  // CntWidth=4

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic [2:0] req_type;
  logic       stb_empty;
  logic       wbuf_empty;
  logic       ack;

  logic ready[4], fdc[4], fic[4], ftlb[4], fvv[4], fgv[4], done[4], ill[4], busy[4];
  logic [15:0] cnt[3];
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;

  fence_flush_ctrl u_wt (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_type_i(req_type),
    .req_ready_o(ready[W]), .stb_empty_i(stb_empty), .wbuf_empty_i(wbuf_empty),
    .flush_dcache_o(fdc[W]), .flush_dcache_ack_i(ack), .flush_icache_o(fic[W]),
    .flush_tlb_o(ftlb[W]), .flush_tlb_vvma_o(fvv[W]), .flush_tlb_gvma_o(fgv[W]),
    .done_o(done[W]), .illegal_o(ill[W]), .busy_o(busy[W]), .busy_cycles_o(cnt[W]));

  fence_flush_ctrl #(.DcacheWriteBack(1'b1)) u_wb (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_type_i(req_type),
    .req_ready_o(ready[B]), .stb_empty_i(stb_empty), .wbuf_empty_i(wbuf_empty),
    .flush_dcache_o(fdc[B]), .flush_dcache_ack_i(ack), .flush_icache_o(fic[B]),
    .flush_tlb_o(ftlb[B]), .flush_tlb_vvma_o(fvv[B]), .flush_tlb_gvma_o(fgv[B]),
    .done_o(done[B]), .illegal_o(ill[B]), .busy_o(busy[B]), .busy_cycles_o(cnt[B]));

  fence_flush_ctrl #(.RVH(1'b0)) u_nh (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_type_i(req_type),
    .req_ready_o(ready[N]), .stb_empty_i(stb_empty), .wbuf_empty_i(wbuf_empty),
    .flush_dcache_o(fdc[N]), .flush_dcache_ack_i(ack), .flush_icache_o(fic[N]),
    .flush_tlb_o(ftlb[N]), .flush_tlb_vvma_o(fvv[N]), .flush_tlb_gvma_o(fgv[N]),
    .done_o(done[N]), .illegal_o(ill[N]), .busy_o(busy[N]), .busy_cycles_o(cnt[N]));

  fence_flush_ctrl #(.CntWidth(4)) u_c4 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_type_i(req_type),
    .req_ready_o(ready[C]), .stb_empty_i(stb_empty), .wbuf_empty_i(wbuf_empty),
    .flush_dcache_o(fdc[C]), .flush_dcache_ack_i(ack), .flush_icache_o(fic[C]),
    .flush_tlb_o(ftlb[C]), .flush_tlb_vvma_o(fvv[C]), .flush_tlb_gvma_o(fgv[C]),
    .done_o(done[C]), .illegal_o(ill[C]), .busy_o(busy[C]), .busy_cycles_o(cnt4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid  = 1'b0;
    req_type   = 3'd0;
    ack        = 1'b0;
    stb_empty  = 1'b1;
    wbuf_empty = 1'b1;
    rst_n      = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Present a request for the accept cycle (cycle 0); returns in cycle 1.
  task automatic issue(input logic [2:0] t);
    req_valid = 1'b1;
    req_type  = t;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_type = 3'd0; ack = 1'b0; stb_empty = 1'b1; wbuf_empty = 1'b1;
    #3;
    // Reset state
    chk("rst_ready", 32'(ready[W]), 1);
    chk("rst_busy",  32'(busy[W]), 0);
    chk("rst_fdc",   32'(fdc[W]), 0);
    chk("rst_done",  32'(done[W]), 0);
    chk("rst_cnt",   32'(cnt[W]), 0);
    do_reset();

    // FENCE_I on write-through D$, buffers empty
    issue(3'd1);
    chk("fi_c1_busy",  32'(busy[W]), 1);
    chk("fi_c1_ready", 32'(ready[W]), 0);
    chk("fi_c1_fdc",   32'(fdc[W]), 0);
    chk("fi_c1_fic",   32'(fic[W]), 0);
    step();
    chk("fi_c2_fic",  32'(fic[W]), 1);
    chk("fi_c2_fdc",  32'(fdc[W]), 0);
    chk("fi_c2_done", 32'(done[W]), 0);
    step();
    chk("fi_c3_done", 32'(done[W]), 1);
    chk("fi_c3_fic",  32'(fic[W]), 0);
    chk("fi_c3_fdc",  32'(fdc[W]), 0);
    step();
    chk("fi_c4_done",  32'(done[W]), 0);
    chk("fi_c4_ready", 32'(ready[W]), 1);
    chk("fi_c4_cnt",   32'(cnt[W]), 3);

    // Plain FENCE: minimum latency of two cycles
    do_reset();
    issue(3'd0);
    chk("f_c1_done", 32'(done[W]), 0);
    step();
    chk("f_c2_done", 32'(done[W]), 1);
    chk("f_c2_fdc",  32'(fdc[W]), 0);
    step();
    chk("f_cnt", 32'(cnt[W]), 2);

    // FENCE_I on write-back D$: write buffer busy 5 cycles, ack in 4th FLUSH_DC cycle
    do_reset();
    wbuf_empty = 1'b0;
    issue(3'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("wb_drain_fdc", 32'(fdc[B]), 0);
      ack = (i == 2);  // ack outside FLUSH_DC must be ignored
      step();
    end
    ack = 1'b0;
    wbuf_empty = 1'b1;
    chk("wb_c5_fdc", 32'(fdc[B]), 0);
    step();
    for (int k = 1; k <= 4; k++) begin
      chk("wb_fdc_hi",  32'(fdc[B]), 1);
      chk("wb_fic_lo",  32'(fic[B]), 0);
      chk("wb_done_lo", 32'(done[B]), 0);
      ack = (k == 4);
      step();
    end
    ack = 1'b0;
    chk("wb_fdc_drop", 32'(fdc[B]), 0);
    chk("wb_fic",      32'(fic[B]), 1);
    step();
    chk("wb_done", 32'(done[B]), 1);
    chk("wb_fic_off", 32'(fic[B]), 0);
    step();
    chk("wb_idle_ready", 32'(ready[B]), 1);
    chk("wb_cnt",        32'(cnt[B]), 11);

    // SFENCE_VMA then HFENCE_GVMA back to back; type changes while busy are ignored
    do_reset();
    issue(3'd2);
    req_type = 3'd3;
    chk("tlb_c1_ready", 32'(ready[W]), 0);
    chk("tlb_c1_tlb",   32'(ftlb[W]), 0);
    step();
    chk("tlb_c2_tlb",  32'(ftlb[W]), 1);
    chk("tlb_c2_vvma", 32'(fvv[W]), 0);
    chk("tlb_c2_gvma", 32'(fgv[W]), 0);
    chk("tlb_c2_ready", 32'(ready[W]), 0);
    req_valid = 1'b1;
    req_type  = 3'd4;
    step();
    chk("tlb_c3_done",  32'(done[W]), 1);
    chk("tlb_c3_tlb",   32'(ftlb[W]), 0);
    chk("tlb_c3_ready", 32'(ready[W]), 0);
    step();
    chk("tlb_c4_ready", 32'(ready[W]), 1);
    chk("tlb_c4_done",  32'(done[W]), 0);
    step();
    req_valid = 1'b0;
    chk("gv_c1_ready", 32'(ready[W]), 0);
    chk("gv_c1_vvma",  32'(fvv[W]), 0);
    step();
    chk("gv_c2_gvma", 32'(fgv[W]), 1);
    chk("gv_c2_tlb",  32'(ftlb[W]), 0);
    chk("gv_c2_vvma", 32'(fvv[W]), 0);
    step();
    chk("gv_c3_done", 32'(done[W]), 1);
    chk("gv_c3_gvma", 32'(fgv[W]), 0);

    // HFENCE_VVMA without hypervisor support is rejected
    do_reset();
    issue(3'd3);
    chk("nh_ill",  32'(ill[N]), 1);
    chk("nh_vvma", 32'(fvv[N]), 0);
    chk("nh_done", 32'(done[N]), 0);
    step();
    chk("nh_ill_off", 32'(ill[N]), 0);
    chk("nh_ready",   32'(ready[N]), 1);
    chk("nh_done2",   32'(done[N]), 0);
    chk("nh_vvma2",   32'(fvv[N]), 0);
    chk("nh_cnt",     32'(cnt[N]), 1);

    // Undefined encoding rejected with RVH=1
    do_reset();
    issue(3'd7);
    chk("u7_ill",  32'(ill[W]), 1);
    chk("u7_fdc",  32'(fdc[W]), 0);
    chk("u7_done", 32'(done[W]), 0);
    step();
    chk("u7_ill_off", 32'(ill[W]), 0);
    chk("u7_fic",     32'(fic[W]), 0);
    chk("u7_tlb",     32'(ftlb[W]), 0);
    chk("u7_done2",   32'(done[W]), 0);
    step();
    chk("u7_done3", 32'(done[W]), 0);

    // Asynchronous reset while in FLUSH_DC
    do_reset();
    issue(3'd1);
    step();
    chk("ar_fdc_before", 32'(fdc[B]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_fdc_async", 32'(fdc[B]), 0);
    chk("ar_ready",     32'(ready[B]), 1);
    chk("ar_cnt",       32'(cnt[B]), 0);
    step();
    rst_n = 1'b1;
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("ar_stale_fdc",  32'(fdc[B]), 0);
    chk("ar_stale_busy", 32'(busy[B]), 0);
    chk("ar_stale_fic",  32'(fic[B]), 0);
    chk("ar_stale_cnt",  32'(cnt[B]), 0);

    // 4-bit counter saturates during a long drain
    do_reset();
    stb_empty = 1'b0;
    issue(3'd0);
    for (int i = 1; i <= 19; i++) begin
      if (i == 10) chk("c4_mid", 32'(cnt4), 9);
      step();
    end
    stb_empty = 1'b1;
    chk("c4_c20_done", 32'(done[C]), 0);
    step();
    chk("c4_done", 32'(done[C]), 1);
    chk("c4_sat",  32'(cnt4), 15);
    step();
    chk("c4_sat_hold", 32'(cnt4), 15);
    chk("c4_ready",    32'(ready[C]), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fence_flush_ctrl.md
Name: fence_flush_ctrl

Overview:
Sequences fence-class instructions at commit: FENCE, FENCE.I, SFENCE.VMA, HFENCE.VVMA and HFENCE.GVMA. It drains the store buffer and write buffer, then issues D$ flush, I$ flush and TLB flush commands in a fixed order. It reports completion to the controller/commit stage, so that stage stalls in a single place instead of tracking several flush handshakes itself. Sits between commit_stage/controller and the cache subsystem and MMU.

Parameters:
DcacheFlushOnFence, 1'b0, FENCE also flushes the D$ when 1.
DcacheWriteBack, 1'b0, 1 = WB D$ (FENCE.I must flush D$); 0 = WT.
RVH, 1'b1, hypervisor fences are legal when 1.
CntWidth, 16, width of the busy-cycle counter.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  fence request from commit
req_type_i  in  3  fence_type_e
req_ready_o  out  1  high only in IDLE
stb_empty_i  in  1  store buffer empty
wbuf_empty_i  in  1  D$ write buffer empty
flush_dcache_o  out  1  level request to D$
flush_dcache_ack_i  in  1  D$ flush complete pulse
flush_icache_o  out  1  one-cycle I$ flush pulse
flush_tlb_o  out  1  one-cycle pulse, SFENCE.VMA
flush_tlb_vvma_o  out  1  one-cycle pulse, HFENCE.VVMA
flush_tlb_gvma_o  out  1  one-cycle pulse, HFENCE.GVMA
done_o  out  1  one-cycle completion pulse
illegal_o  out  1  one-cycle pulse, rejected request
busy_o  out  1  state != IDLE
busy_cycles_o  out  CntWidth  cycles spent by the last or current request

Behaviour:
- Reset: state IDLE; all outputs 0 except req_ready_o=1; busy_cycles_o=0. An asynchronous reset during any state returns to IDLE at once. A pending flush_dcache_o drops immediately.
- Accept: on req_valid_i & req_ready_o.
  - busy_cycles_o clears to 0, then increments every non-IDLE cycle and saturates at all-ones.
- Illegal request: req_type_i is not one of the five encodings, or is an HFENCE type with RVH=0.
  - Next state is ILLEGAL, which pulses illegal_o for one cycle, then returns to IDLE.
  - No flush output asserts.
- States: IDLE, DRAIN, FLUSH_DC, FLUSH_IC, FLUSH_TLB, DONE, ILLEGAL.
- DRAIN: hold until stb_empty_i & wbuf_empty_i in the same cycle. Next state depends on the latched type:
  - FENCE: FLUSH_DC if DcacheFlushOnFence, else DONE.
  - FENCE_I: FLUSH_DC if DcacheFlushOnFence or DcacheWriteBack, else FLUSH_IC.
  - SFENCE/HFENCE types: FLUSH_TLB.
- FLUSH_DC: flush_dcache_o=1 for every cycle in this state.
  - flush_dcache_ack_i is sampled here only; an ack in any other state is ignored.
  - On ack: FENCE_I goes to FLUSH_IC, FENCE goes to DONE.
  - flush_dcache_o drops in the cycle after the ack.
- FLUSH_IC: flush_icache_o=1 for exactly one cycle, then DONE.
- FLUSH_TLB: exactly one of the three TLB outputs pulses for one cycle, selected by the latched type, then DONE.
- DONE: done_o=1 for one cycle, then IDLE. A new request can be accepted in the following cycle.
- Minimum latency, accept to done_o: 2 cycles (FENCE, buffers already empty).
  - FENCE_I on WT: 3 cycles.
  - FLUSH_DC path: 3 + ack-wait cycles.
- Outputs are registered-state decodes with no combinational path from req_* to the flush outputs. Exception: req_ready_o is a state decode.
- req_type_i is latched at accept; changes while busy have no effect.
- Simultaneous stb_empty_i rise and ack: irrelevant, because states are sequential.
- The ack may arrive on the first FLUSH_DC cycle; the state is then left after 1 cycle.

Decomposition:
- Package fence_ctrl_pkg: fence_type_e (FENCE=3'd0, FENCE_I=3'd1, SFENCE_VMA=3'd2, HFENCE_VVMA=3'd3, HFENCE_GVMA=3'd4) and fence_state_e.
- Parameters are fed from cva6_cfg fields DcacheFlushOnFence, DCacheType==WB and RVH at instantiation.
- One natural sub-module: sat_counter (saturating, clearable) for busy_cycles_o.
- Everything else stays in a single FSM.

Test Plan:
- FENCE_I, WT, stb_empty_i=wbuf_empty_i=1 at accept (cycle 0):
  - flush_icache_o=1 in cycle 2, done_o=1 in cycle 3.
  - flush_dcache_o is never asserted; busy_cycles_o=3.
- FENCE_I with DcacheWriteBack=1; wbuf_empty_i held low 5 cycles; ack 4 cycles after FLUSH_DC entry:
  - Strict order: flush_dcache_o high for exactly 4 cycles, then flush_icache_o pulse, then done_o.
- SFENCE_VMA, then HFENCE_GVMA issued back to back:
  - First: flush_tlb_o pulses once; second: flush_tlb_gvma_o pulses once.
  - flush_tlb_vvma_o stays 0 throughout; req_ready_o is 0 between accept and done.
- RVH=0, HFENCE_VVMA request:
  - illegal_o pulses 1 cycle after accept; no flush outputs; done_o never asserts.
  - req_type_i=3'd7 gives the same response with RVH=1.
- rst_ni low while in FLUSH_DC:
  - flush_dcache_o=0 within the reset assertion, without waiting for a clock edge.
  - After release: IDLE, req_ready_o=1, busy_cycles_o=0; a stale ack is ignored.
- CntWidth=4, DRAIN held for 20 cycles: busy_cycles_o saturates at 4'hF, and done_o still follows normally.
